// File: rtl/miinst_issue_queue.sv
// Micro-instruction issue queue: buffers fetch bundles and issues their live slots one per cycle.
// Optional same-cycle bypass into an empty queue is enabled by defining MIQ_BYPASS_EN.
`ifndef MQ_N
`define MQ_N 4
`endif

package miinst_pkg;
    typedef enum logic [3:0] {
        MIOP_NOP   = 4'd0,
        MIOP_ADDI  = 4'd1,
        MIOP_LOAD  = 4'd2,
        MIOP_JR    = 4'd3,
        MIOP_ADD   = 4'd4,
        MIOP_SUB   = 4'd5,
        MIOP_STORE = 4'd6
    } miop_e;

    typedef struct packed {
        miop_e       op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [11:0] imm;
    } miinst_t;

    localparam int MIINST_W = $bits(miinst_t);
endpackage

module miinst_issue_queue
    import miinst_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NSLOT = `MQ_N
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          bundle_valid,
    input  logic [NSLOT*MIINST_W-1:0]     bundle,
    output logic                          bundle_ready,
    output logic                          issue_valid,
    output logic [MIINST_W-1:0]           issue_inst,
    input  logic                          issue_ready,
    output logic [$clog2(DEPTH):0]        occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [SW-1:0]       slot_ptr;
    logic [PW:0]         count;

    logic [MIINST_W-1:0] slots [DEPTH][NSLOT];
    logic [NSLOT-1:0]    live  [DEPTH];

    miinst_t             in_slot [NSLOT];
    logic [NSLOT-1:0]    in_live;
    logic [NSLOT-1:0]    wr_mask;
    logic [NSLOT-1:0]    head_live;
    logic [NSLOT-1:0]    head_avail;
    logic [NSLOT-1:0]    head_left;
    logic [SW-1:0]       head_idx;
    logic                empty;
    logic                enq_fire;
    logic                enq_write;
    logic                issue_fire;
    logic                head_fire;
    logic                retire;
`ifdef MIQ_BYPASS_EN
    logic [SW-1:0]       in_idx;
    logic                bypass;
`endif

    assign empty        = (count == '0);
    assign bundle_ready = (count < (PW+1)'(DEPTH)) && !flush;
    assign enq_fire     = bundle_valid && bundle_ready;
    assign occupancy    = count;

    // Unpack the incoming bundle and mark the slots that carry real work.
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            in_slot[i] = bundle[i*MIINST_W +: MIINST_W];
            in_live[i] = (in_slot[i].op != MIOP_NOP);
        end
    end

    // Lowest live slot of the head bundle at or beyond slot_ptr.
    always_comb begin
        head_live = live[rd_ptr];
        head_idx  = '0;
        for (int i = 0; i < NSLOT; i++) begin
            head_avail[i] = head_live[i] && (SW'(i) >= slot_ptr);
        end
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (head_avail[i]) begin
                head_idx = SW'(i);
            end
        end
        head_left           = head_live;
        head_left[head_idx] = 1'b0;
    end

`ifdef MIQ_BYPASS_EN
    always_comb begin
        in_idx = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (in_live[i]) begin
                in_idx = SW'(i);
            end
        end
    end

    assign bypass = empty && enq_fire && (|in_live);
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        issue_valid = 1'b0;
        issue_inst  = '0;
        if (!flush && !empty) begin
            issue_valid = 1'b1;
            issue_inst  = slots[rd_ptr][head_idx];
        end
`ifdef MIQ_BYPASS_EN
        else if (bypass) begin
            issue_valid = 1'b1;
            issue_inst  = in_slot[in_idx];
        end
`endif
    end

    assign issue_fire = issue_valid && issue_ready;
    assign head_fire  = issue_fire && !empty;
    assign retire     = head_fire && (head_left == '0);

    always_comb begin
        wr_mask = in_live;
`ifdef MIQ_BYPASS_EN
        if (bypass && issue_ready) begin
            wr_mask[in_idx] = 1'b0;
        end
`endif
    end

    assign enq_write = enq_fire && (|wr_mask);

    // wr_ptr and rd_ptr only coincide when empty (no head issue) or full (no enqueue),
    // so the two live-mask writes below never target the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            slot_ptr <= '0;
            count    <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                live[d] <= '0;
            end
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            slot_ptr <= '0;
            count    <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                live[d] <= '0;
            end
        end else begin
            if (enq_write) begin
                live[wr_ptr] <= wr_mask;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (head_fire) begin
                live[rd_ptr] <= head_left;
                if (retire) begin
                    rd_ptr   <= rd_ptr + PW'(1);
                    slot_ptr <= '0;
                end else begin
                    slot_ptr <= head_idx + SW'(1);
                end
            end
            case ({enq_write, retire})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: slot payload storage has no reset; the live masks alone decide what is valid.
    always_ff @(posedge clk) begin
        if (enq_write) begin
            for (int s = 0; s < NSLOT; s++) begin
                slots[wr_ptr][s] <= in_slot[s];
            end
        end
    end

endmodule

// File: tb/tb_miinst_issue_queue.sv
// Scoreboard bench for miinst_issue_queue: directed bundles, expected issues queued, monitor compares.
`ifndef MQ_N
`define MQ_N 4
`endif

module tb_miinst_issue_queue;
    import miinst_pkg::*;

    localparam int DEPTH = 4;
    localparam int NSLOT = `MQ_N;
    localparam int W     = MIINST_W;
`ifdef MIQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 flush = 1'b0;
    logic                 bundle_valid = 1'b0;
    logic [NSLOT*W-1:0]   bundle = '0;
    logic                 bundle_ready;
    logic                 issue_valid;
    logic [W-1:0]         issue_inst;
    logic                 issue_ready = 1'b0;
    logic [$clog2(DEPTH):0] occupancy;

    int checks   = 0;
    int failures = 0;
    int issued   = 0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    miinst_issue_queue #(.DEPTH(DEPTH), .NSLOT(NSLOT)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bundle_valid (bundle_valid),
        .bundle       (bundle),
        .bundle_ready (bundle_ready),
        .issue_valid  (issue_valid),
        .issue_inst   (issue_inst),
        .issue_ready  (issue_ready),
        .occupancy    (occupancy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic miinst_t mk(input miop_e op, input logic [11:0] imm);
        miinst_t m;
        m.op  = op;
        m.rd  = imm[4:0];
        m.rs1 = 5'd3;
        m.imm = imm;
        return m;
    endfunction

    function automatic logic [NSLOT*W-1:0] mkb(input miinst_t s0, input miinst_t s1,
                                               input miinst_t s2, input miinst_t s3);
        return {s3, s2, s1, s0};
    endfunction

    // Monitor: every accepted issue must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && issue_valid && issue_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue actual=0x%0h expected=none", issue_inst);
                end else begin
                    check("issue_order", issue_inst, exp_q.pop_front());
                end
                issued++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic enqueue(input logic [NSLOT*W-1:0] b);
        bit ok = 1'b0;
        bundle       = b;
        bundle_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bundle_ready;
        end
        if (!ok) check("enqueue_timeout", 32'd0, 32'd1);
        step();
        bundle_valid = 1'b0;
        bundle       = '0;
    endtask

    miinst_t nop0;
    miinst_t i_a, i_b, i_c, i_d, i_e, i_f, i_g, i_h;
    int base;

    initial begin
        nop0 = mk(MIOP_NOP, 12'h000);

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_issue_valid", issue_valid, 0);
        check("rst_issue_inst", issue_inst, 0);
        check("rst_bundle_ready", bundle_ready, 1);
        check("rst_occupancy", occupancy, 0);
        step();
        rst = 1'b0;

        // Single ADDI: one-cycle latency, occupancy back to zero
        issue_ready = 1'b1;
        i_a = mk(MIOP_ADDI, 12'h011);
        exp_q.push_back(i_a);
        bundle       = mkb(i_a, nop0, nop0, nop0);
        bundle_valid = 1'b1;
        @(negedge clk);
        check("t1_ready", bundle_ready, 1);
        check("t1_valid_accept_cycle", issue_valid, BYP);
        step();
        bundle_valid = 1'b0;
        bundle       = '0;
        @(negedge clk);
        check("t1_valid_next_cycle", issue_valid, !BYP);
        check("t1_occ_next_cycle", occupancy, BYP ? 0 : 1);
        step();
        @(negedge clk);
        check("t1_occ_drained", occupancy, 0);
        check("t1_valid_drained", issue_valid, 0);

        // LOAD, ADDI, JR, NOP: three back-to-back issues, NOP skipped
        step();
        base = issued;
        i_a = mk(MIOP_LOAD, 12'h021);
        i_b = mk(MIOP_ADDI, 12'h022);
        i_c = mk(MIOP_JR,   12'h023);
        exp_q.push_back(i_a);
        exp_q.push_back(i_b);
        exp_q.push_back(i_c);
        enqueue(mkb(i_a, i_b, i_c, nop0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t2_valid_run", issue_valid, BYP ? (c < 2) : 1);
        end
        @(negedge clk);
        check("t2_valid_after", issue_valid, 0);
        #2;
        check("t2_issued", issued - base, 3);

        // Fill to DEPTH with issue stalled, then drain across the pointer wrap
        step();
        issue_ready = 1'b0;
        i_a = mk(MIOP_ADD,   12'h031);
        i_b = mk(MIOP_SUB,   12'h032);
        i_c = mk(MIOP_STORE, 12'h033);
        i_d = mk(MIOP_ADDI,  12'h034);
        i_e = mk(MIOP_JR,    12'h035);
        i_f = mk(MIOP_LOAD,  12'h036);
        i_g = mk(MIOP_LOAD,  12'h037);
        i_h = mk(MIOP_LOAD,  12'h038);
        exp_q.push_back(i_a); exp_q.push_back(i_b); exp_q.push_back(i_c); exp_q.push_back(i_d);
        exp_q.push_back(i_e); exp_q.push_back(i_f); exp_q.push_back(i_g); exp_q.push_back(i_h);
        enqueue(mkb(i_a, i_b, nop0, nop0));
        enqueue(mkb(i_c, nop0, nop0, nop0));
        enqueue(mkb(nop0, i_d, nop0, i_e));
        enqueue(mkb(i_f, i_g, i_h, nop0));
        @(negedge clk);
        check("t3_full_occ", occupancy, 4);
        check("t3_full_ready", bundle_ready, 0);
        check("t3_hold_valid", issue_valid, 1);
        check("t3_hold_inst", issue_inst, i_a);
        step();
        issue_ready = 1'b1;
        @(negedge clk);
        check("t3_ready_first_issue", bundle_ready, 0);
        @(negedge clk);
        check("t3_ready_retire_cycle", bundle_ready, 0);
        check("t3_occ_retire_cycle", occupancy, 4);
        @(negedge clk);
        check("t3_ready_after_retire", bundle_ready, 1);
        check("t3_occ_after_retire", occupancy, 3);
        for (int k = 0; k < 40 && occupancy != 0; k++) @(negedge clk);
        check("t3_drained_occ", occupancy, 0);
        #2;
        check("t3_exp_empty", exp_q.size(), 0);

        // All-NOP bundle: accepted, nothing stored, nothing issued
        step();
        enqueue(mkb(mk(MIOP_NOP, 12'h041), mk(MIOP_NOP, 12'h042), nop0, nop0));
        @(negedge clk);
        check("t4_occ", occupancy, 0);
        check("t4_valid", issue_valid, 0);

        // Flush with three bundles queued and slot_ptr = 1
        step();
        issue_ready = 1'b0;
        i_a = mk(MIOP_ADD,   12'h051);
        i_b = mk(MIOP_SUB,   12'h052);
        i_c = mk(MIOP_JR,    12'h053);
        i_d = mk(MIOP_STORE, 12'h054);
        exp_q.push_back(i_a);
        enqueue(mkb(i_a, i_b, nop0, nop0));
        enqueue(mkb(i_c, nop0, nop0, nop0));
        enqueue(mkb(i_d, nop0, nop0, nop0));
        issue_ready = 1'b1;
        step();
        flush        = 1'b1;
        bundle_valid = 1'b1;
        bundle       = mkb(mk(MIOP_ADDI, 12'h05f), nop0, nop0, nop0);
        @(negedge clk);
        check("t5_flush_valid", issue_valid, 0);
        check("t5_flush_ready", bundle_ready, 0);
        check("t5_flush_occ", occupancy, 3);
        step();
        flush        = 1'b0;
        bundle_valid = 1'b0;
        bundle       = '0;
        @(negedge clk);
        check("t5_post_occ", occupancy, 0);
        check("t5_post_valid", issue_valid, 0);
        step();
        i_e = mk(MIOP_ADDI, 12'h061);
        i_f = mk(MIOP_JR,   12'h062);
        exp_q.push_back(i_e);
        exp_q.push_back(i_f);
        enqueue(mkb(i_e, i_f, nop0, nop0));
        repeat (4) @(negedge clk);
        #2;
        check("t5_exp_empty", exp_q.size(), 0);
        check("t5_occ_end", occupancy, 0);

        // Asynchronous reset mid-stall
        step();
        issue_ready = 1'b0;
        enqueue(mkb(mk(MIOP_LOAD, 12'h071), mk(MIOP_ADD, 12'h072), nop0, nop0));
        @(negedge clk);
        check("t6_stall_valid", issue_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", issue_valid, 0);
        check("t6_rst_occ", occupancy, 0);
        check("t6_rst_ready", bundle_ready, 1);
        step();
        rst = 1'b0;
        issue_ready = 1'b1;
        i_g = mk(MIOP_SUB, 12'h081);
        exp_q.push_back(i_g);
        enqueue(mkb(nop0, nop0, i_g, nop0));
        repeat (3) @(negedge clk);
        #2;
        check("t6_exp_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/miinst_issue_queue.md
Name: miinst_issue_queue

Overview:
- Consumer end of the fetch-phase micro-instruction bundle interface. Accepts one bundle of `MQ_N miinst_t slots per handshake from the fetch/decode phases.
- Buffers bundles and issues the non-NOP slots one per cycle, in slot order, to the execute stage.
- Drains the decode output so fetch can stall on backpressure. Discards all in-flight work on a pipeline flush.

Parameters:
- DEPTH, 4, number of bundle entries; must be a power of two and at least 2.
- NSLOT, `MQ_N, slots per bundle.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous flush (jump/redirect); drops all entries.
- bundle_valid  input  1  fetch presents a complete bundle (the decoder's valid).
- bundle  input  NSLOT x $bits(miinst_t)  slots; slot 0 is the oldest.
- bundle_ready  output  1  queue can accept a bundle this cycle.
- issue_valid  output  1  issue_inst is valid.
- issue_inst  output  $bits(miinst_t)  micro-instruction being issued.
- issue_ready  input  1  execute stage takes issue_inst.
- occupancy  output  $clog2(DEPTH)+1  number of stored bundles.

Behaviour:
- Reset (asynchronous):
  - wr_ptr = rd_ptr = slot_ptr = 0, count = 0.
  - Outputs: issue_valid = 0, issue_inst = nop(0), bundle_ready = 1, occupancy = 0.
- Storage: circular buffer of DEPTH bundles, each stored with an NSLOT-bit live mask. A mask bit is 1 when that slot's op != MIOP_NOP.
- Enqueue:
  - Fires when bundle_valid && bundle_ready. bundle_ready = (count < DEPTH) && !flush.
  - A bundle whose live mask is all zero is accepted but not written (no count change).
  - Otherwise the bundle is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Issue selection:
  - slot_ptr indexes the head bundle.
  - issue_inst = the head slot at the lowest live index >= slot_ptr.
  - issue_valid = (count != 0) && !flush.
- Issue handshake:
  - Fires when issue_valid && issue_ready.
  - The issued slot's live bit is cleared.
  - If no live bit remains in the head, the head retires in the same cycle: rd_ptr increments, slot_ptr returns to 0, count decrements.
  - Otherwise slot_ptr becomes the issued index + 1.
- Hold: while issue_valid && !issue_ready, issue_inst and issue_valid stay stable, and the queue state does not change except for enqueue.
- Latency:
  - The earliest issue_valid for an accepted bundle is the cycle after acceptance.
  - Sustained throughput is 1 live slot per cycle.
- Simultaneous enqueue and retire:
  - count stays unchanged.
  - When full (count = DEPTH), bundle_ready is 0 even if the head retires this cycle; there is no same-cycle free-slot bypass.
- Wrap-around: both pointers wrap modulo DEPTH. count is the sole full/empty discriminator.
- Flush:
  - Highest priority. In the flush cycle issue_valid = 0 and bundle_ready = 0, and neither handshake fires.
  - On the next edge all pointers and count go to 0 and all live masks clear.
- Reset mid-operation: identical to flush but asynchronous; any partially issued bundle is lost.
- Ordering: slots issue strictly in bundle order, then slot order; no reordering or skipping of live slots.

Optional Feature:
- Macro: MIQ_BYPASS_EN.
- Defined:
  - When count = 0 and an enqueue fires with a non-empty live mask, the first live slot of the incoming bundle drives issue_inst combinationally with issue_valid = 1 in the same cycle.
  - If issue_ready is also 1, that slot is consumed. The remaining live slots (if any) are written with that bit cleared; otherwise nothing is written.
  - Zero-cycle latency when the queue is empty.
- Undefined: no combinational path from bundle to issue_inst; minimum latency is 1 cycle.

Test Plan:
- Reset then single bundle {MIOP_ADDI, NOP, NOP, NOP}, issue_ready = 1 -> issue_valid high exactly 1 cycle after acceptance (0 cycles with MIQ_BYPASS_EN) with op = MIOP_ADDI; occupancy returns to 0.
- Bundle {load_on_pop, addi_on_pop, MIOP_JR, NOP} -> three consecutive issue cycles in order LOAD, ADDI, JR; the NOP is never issued.
- issue_ready = 0, push DEPTH = 4 bundles -> bundle_ready drops after the 4th and occupancy = 4. Raise issue_ready and drain all -> bundle_ready returns to 1 the cycle after the first retire. Pointers wrap and order is preserved.
- All-NOP bundle accepted -> occupancy unchanged, issue_valid stays 0.
- flush asserted while 3 bundles are queued and slot_ptr = 1 -> in that cycle issue_valid = 0 and bundle_ready = 0; next cycle occupancy = 0, and a new bundle issues normally from slot 0.
- rst pulsed asynchronously mid-stall with issue_valid = 1 -> issue_valid drops immediately (before the next edge), occupancy = 0, bundle_ready = 1.
